dispense_scheduler: RTL and testbench

DISPENSE_SCHEDULER -- requirements
Module: dispense_scheduler

---
 rtl/vend_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/dispense_scheduler.sv | 117 +++++++++++
 tb/tb_dispense_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM state and item encodings, dispense length default.
// No timing of its own; no handshake.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2,
    ST_REJECT   = 2'd3
  } state_t;

  typedef enum logic {
    ITEM_TEA    = 1'b0,
    ITEM_COFFEE = 1'b1
  } item_t;

  localparam int DISP_CYCLES_DEF = 4;
  // Wide enough for the largest legal DISP_CYCLES-1 (14).
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way winner pick: a lone requester wins, a tie goes to the panel named by rr.
// Combinational, zero latency; no backpressure (the caller only consults it in IDLE).
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    grant = rr;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = rr;
    endcase
  end

  assign valid = |req;

endmodule

// File: rtl/dispense_scheduler.sv
// Two-panel vend scheduler with tea/coffee stock; motor on cycles k+1..k+DISP_CYCLES, ack at k+DISP_CYCLES+1, nack at k+1.
// Panels hold req until ack/nack; requests and restock are ignored while busy.
module dispense_scheduler
  import vend_pkg::*;
#(
  parameter int DISP_CYCLES = DISP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] sel,
  input  logic       load,
  input  logic [1:0] tea_load,
  input  logic [1:0] coffee_load,
  output logic [1:0] ack,
  output logic [1:0] nack,
  output logic       motor_tea,
  output logic       motor_coffee,
  output logic       busy,
  output logic [1:0] tea_avail,
  output logic [1:0] coffee_avail
);

  localparam logic [CNT_W-1:0] CYC_LOAD = CNT_W'(DISP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             win, win_nxt;
  item_t            item, item_nxt;
  logic             rr, rr_nxt;
  logic [1:0]       tea_stock, tea_nxt;
  logic [1:0]       coffee_stock, coffee_nxt;

  logic             grant_idx;
  logic             grant_vld;
  item_t            req_item;
  logic             stock_ok;

  rr_arbiter2 u_arb (
    .req   (req),
    .rr    (rr),
    .grant (grant_idx),
    .valid (grant_vld)
  );

  assign req_item = item_t'(sel[grant_idx]);
  assign stock_ok = (req_item == ITEM_TEA) ? (tea_stock != 2'd0) : (coffee_stock != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      win          <= 1'b0;
      item         <= ITEM_TEA;
      rr           <= 1'b0;
      tea_stock    <= 2'd0;
      coffee_stock <= 2'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      win          <= win_nxt;
      item         <= item_nxt;
      rr           <= rr_nxt;
      tea_stock    <= tea_nxt;
      coffee_stock <= coffee_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    win_nxt    = win;
    item_nxt   = item;
    rr_nxt     = rr;
    tea_nxt    = tea_stock;
    coffee_nxt = coffee_stock;
    case (state)
      ST_IDLE: begin
        // Restock wins over any pending request in the same cycle.
        if (load) begin
          tea_nxt    = tea_load;
          coffee_nxt = coffee_load;
        end else if (grant_vld) begin
          win_nxt = grant_idx;
          if (stock_ok) begin
            item_nxt  = req_item;
            cnt_nxt   = CYC_LOAD;
            state_nxt = ST_DISPENSE;
            if (req_item == ITEM_TEA) tea_nxt = tea_stock - 2'd1;
            else                      coffee_nxt = coffee_stock - 2'd1;
          end else begin
            state_nxt = ST_REJECT;
          end
        end
      end
      ST_DISPENSE: begin
        if (cnt == '0) state_nxt = ST_DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ST_DONE, ST_REJECT: begin
        rr_nxt    = ~win;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs: decoded from registered state only.
  assign busy         = (state != ST_IDLE);
  assign motor_tea    = (state == ST_DISPENSE) && (item == ITEM_TEA);
  assign motor_coffee = (state == ST_DISPENSE) && (item == ITEM_COFFEE);
  assign ack          = {(state == ST_DONE) && win, (state == ST_DONE) && !win};
  assign nack         = {(state == ST_REJECT) && win, (state == ST_REJECT) && !win};
  assign tea_avail    = tea_stock;
  assign coffee_avail = coffee_stock;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Directed bench for dispense_scheduler: restock, single vend, tie-break, reject,
// load priority, load-while-busy and mid-dispense reset.
module tb_dispense_scheduler;

  logic       clk;
  logic       rst;
  logic [1:0] req;
  logic [1:0] sel;
  logic       load;
  logic [1:0] tea_load;
  logic [1:0] coffee_load;
  logic [1:0] ack;
  logic [1:0] nack;
  logic       motor_tea;
  logic       motor_coffee;
  logic       busy;
  logic [1:0] tea_avail;
  logic [1:0] coffee_avail;

  int checks = 0;
  int errors = 0;

  dispense_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .sel          (sel),
    .load         (load),
    .tea_load     (tea_load),
    .coffee_load  (coffee_load),
    .ack          (ack),
    .nack         (nack),
    .motor_tea    (motor_tea),
    .motor_coffee (motor_coffee),
    .busy         (busy),
    .tea_avail    (tea_avail),
    .coffee_avail (coffee_avail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {motor_tea, motor_coffee, ack, nack, busy}
  function automatic logic [6:0] ctl();
    return {motor_tea, motor_coffee, ack, nack, busy};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req = 2'b00; sel = 2'b00; load = 1'b0; tea_load = 2'd0; coffee_load = 2'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'd0) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'd0);
    end
  endtask

  task automatic test_single_tea();
    load = 1'b1; tea_load = 2'd2; coffee_load = 2'd2;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({tea_avail, coffee_avail, busy} !== 5'b10_10_0) begin
      errors++;
      $display("FAIL tea_restock: got %b expected %b", {tea_avail, coffee_avail, busy}, 5'b10_10_0);
    end
    req = 2'b01; sel = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl() !== 7'b10_00_00_1) begin
        errors++;
        $display("FAIL tea_motor_cyc%0d: got %b expected %b", i + 1, ctl(), 7'b10_00_00_1);
      end
    end
    @(negedge clk);
    checks++;
    if (ctl() !== 7'b00_01_00_1) begin
      errors++;
      $display("FAIL tea_ack: got %b expected %b", ctl(), 7'b00_01_00_1);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'b00_00_00_0_01_10) begin
      errors++;
      $display("FAIL tea_after: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'b00_00_00_0_01_10);
    end
  endtask

  task automatic test_back_to_back();
    // Fresh reset so the round-robin pointer starts at panel 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b1; tea_load = 2'd2; coffee_load = 2'd2;
    @(negedge clk);
    load = 1'b0;
    req = 2'b11; sel = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl() !== 7'b01_00_00_1) begin
        errors++;
        $display("FAIL b2b_p0_motor_cyc%0d: got %b expected %b", i + 1, ctl(), 7'b01_00_00_1);
      end
    end
    @(negedge clk);
    checks++;
    if ({ctl(), coffee_avail} !== 9'b00_01_00_1_01) begin
      errors++;
      $display("FAIL b2b_p0_ack: got %b expected %b", {ctl(), coffee_avail}, 9'b00_01_00_1_01);
    end
    req = 2'b10;
    @(negedge clk);
    checks++;
    if (ctl() !== 7'b00_00_00_0) begin
      errors++;
      $display("FAIL b2b_gap_idle: got %b expected %b", ctl(), 7'b00_00_00_0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ctl() !== 7'b01_00_00_1) begin
        errors++;
        $display("FAIL b2b_p1_motor_cyc%0d: got %b expected %b", i + 1, ctl(), 7'b01_00_00_1);
      end
    end
    @(negedge clk);
    checks++;
    if ({ctl(), coffee_avail, tea_avail} !== 11'b00_10_00_1_00_10) begin
      errors++;
      $display("FAIL b2b_p1_ack: got %b expected %b", {ctl(), coffee_avail, tea_avail}, 11'b00_10_00_1_00_10);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reject();
    req = 2'b10; sel = 2'b10;
    @(negedge clk);
    checks++;
    if (ctl() !== 7'b00_00_10_1) begin
      errors++;
      $display("FAIL reject_nack: got %b expected %b", ctl(), 7'b00_00_10_1);
    end
    req = 2'b00;
    @(negedge clk);
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'b00_00_00_0_10_00) begin
      errors++;
      $display("FAIL reject_after: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'b00_00_00_0_10_00);
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; tea_load = 2'd1; coffee_load = 2'd3;
    req = 2'b01; sel = 2'b01;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'b00_00_00_0_01_11) begin
      errors++;
      $display("FAIL loadpri_nogrant: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'b00_00_00_0_01_11);
    end
    @(negedge clk);
    checks++;
    if ({ctl(), coffee_avail} !== 9'b01_00_00_1_10) begin
      errors++;
      $display("FAIL loadpri_grant: got %b expected %b", {ctl(), coffee_avail}, 9'b01_00_00_1_10);
    end
    repeat (3) @(negedge clk);
    @(negedge clk);
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL loadpri_ack: got %b expected %b", ack, 2'b01);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_busy_load_and_reset();
    req = 2'b01; sel = 2'b00;
    @(negedge clk);
    checks++;
    if ({motor_tea, tea_avail} !== 3'b1_00) begin
      errors++;
      $display("FAIL busy_motor1: got %b expected %b", {motor_tea, tea_avail}, 3'b1_00);
    end
    load = 1'b1; tea_load = 2'd3; coffee_load = 2'd3;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if ({motor_tea, tea_avail, coffee_avail} !== 5'b1_00_10) begin
      errors++;
      $display("FAIL busy_load_ignored: got %b expected %b", {motor_tea, tea_avail, coffee_avail}, 5'b1_00_10);
    end
    rst = 1'b1; req = 2'b00;
    #1;
    checks++;
    if ({ctl(), tea_avail, coffee_avail} !== 11'd0) begin
      errors++;
      $display("FAIL midrst_immediate: got %b expected %b", {ctl(), tea_avail, coffee_avail}, 11'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (ctl() !== 7'd0) begin
        errors++;
        $display("FAIL midrst_quiet_cyc%0d: got %b expected %b", i, ctl(), 7'd0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_tea();
    test_back_to_back();
    test_reject();
    test_load_priority();
    test_busy_load_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
